pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Controls the board's single iCE40 PLL primitive wrapper, which has an active-low RESET input and a LOCK output.
- Holds the PLL in reset at power-up, waits for lock and requires lock to stay stable before it releases the system reset.
- Watches for loss of lock and re-sequences the PLL, with bounded retries and a latched fault.
- Runs on the raw reference clock (12 MHz), because the PLL output is not valid until lock.

Parameters:
- RST_CYCLES, 16: number of cycles PLL_RESETB is held low in each HOLD pass.
- LOCK_TIMEOUT, 12000: cycles allowed in WAIT for lock (1 ms at 12 MHz).
- STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before RUN.
- LOSS_CYCLES, 4: consecutive synchronized-unlock cycles in RUN that count as lock loss.
- MAX_RETRIES, 3: failed attempts allowed before entering FAIL.

Ports:
- CLK  in  1  reference clock; all logic is on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- PLL_LOCK  in  1  LOCK output of the PLL; asynchronous to CLK.
- RELOCK  in  1  single-cycle request to re-sequence the PLL; also clears FAIL.
- PLL_RESETB  out  1  drives the PLL's active-low RESET input.
- SYS_RST  out  1  active-high reset for downstream logic; consumers re-synchronize it into the PLL output domain.
- LOCKED  out  1  high only in RUN.
- FAULT  out  1  high only in FAIL.
- RETRY_CNT  out  $clog2(MAX_RETRIES+1)  failed attempts since the last RUN or RELOCK.
- STATE  out  3  current state encoding, for debug.

Behaviour:
- One clock (CLK). RESET is synchronous and active-high.
- Precedence: RESET > RELOCK > lock events.
- Synchronizer: PLL_LOCK passes through 2 flops to give LOCK_S. Latency is 2 cycles. Both flops reset to 0.
- States (STATE encoding): HOLD=0, WAIT=1, SETTLE=2, RUN=3, FAIL=4. Encodings 5..7 go to HOLD.
- Moore outputs, decoded from the state register:
  - PLL_RESETB = 0 in HOLD and FAIL, 1 otherwise.
  - SYS_RST = 0 only in RUN.
  - LOCKED = (state==RUN).
  - FAULT = (state==FAIL).
- Counters:
  - One shared cycle counter CNT, sized $clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES. It is cleared on every state transition.
  - A separate loss counter LCNT is used in RUN only. It is cleared whenever LOCK_S=1 and on entry to RUN.
- Reset values: state=HOLD, CNT=0, LCNT=0, RETRY_CNT=0. Hence PLL_RESETB=0, SYS_RST=1, LOCKED=0, FAULT=0, STATE=0.
- HOLD: CNT increments. When CNT==RST_CYCLES-1, go to WAIT. PLL_RESETB is therefore low for exactly RST_CYCLES cycles.
- WAIT:
  - If LOCK_S=1, go to SETTLE.
  - Else if CNT==LOCK_TIMEOUT-1, take the RETRY path.
- SETTLE:
  - If LOCK_S=0, take the RETRY path; a flapping lock counts as a failure.
  - Else if CNT==STABLE_CYCLES-1, go to RUN and clear RETRY_CNT.
- RUN:
  - If LOCK_S=0, LCNT increments. When LCNT reaches LOSS_CYCLES-1 with LOCK_S=0, take the RETRY path.
  - Dropouts shorter than LOSS_CYCLES are ignored.
  - SYS_RST reasserts in the first cycle the state leaves RUN.
- RETRY path: if RETRY_CNT==MAX_RETRIES, go to FAIL. Otherwise RETRY_CNT increments (saturating) and the state goes to HOLD.
- FAIL: terminal. It is left only by RELOCK or RESET.
- RELOCK:
  - In any state, RELOCK sends the state to HOLD, clears CNT and LCNT, and leaves RETRY_CNT unchanged.
  - In FAIL, RELOCK also clears RETRY_CNT.
  - RELOCK held high keeps the block in HOLD.
- Reset mid-operation: RESET in any state returns everything to reset values on the next edge. A pending RELOCK is discarded.
- PLL_LOCK high while in HOLD is ignored.

Test Plan:
Overrides for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, LOSS_CYCLES=3, MAX_RETRIES=2.
- Nominal bring-up: release RESET; PLL_LOCK rises 6 cycles after PLL_RESETB rises -> PLL_RESETB low for exactly 4 cycles; SYS_RST falls 2+1+8 cycles after PLL_LOCK rises; LOCKED=1; RETRY_CNT=0.
- Glitch tolerance: in RUN, pull PLL_LOCK low for 2 cycles -> stays in RUN with SYS_RST=0. Pull it low for 3 cycles -> SYS_RST=1, state HOLD, RETRY_CNT=1.
- Timeout and fault: hold PLL_LOCK=0 -> three WAIT timeouts, RETRY_CNT steps 1, 2, then FAIL with FAULT=1, PLL_RESETB=0, SYS_RST=1. Pulse RELOCK -> HOLD, FAULT=0, RETRY_CNT=0.
- Settle flapping: PLL_LOCK high for 5 cycles, then low, during SETTLE -> RETRY path, RETRY_CNT=1, never reaches RUN. Next attempt with stable lock reaches RUN and RETRY_CNT=0.
- RELOCK in RUN: one-cycle pulse -> next cycle state HOLD, SYS_RST=1, PLL_RESETB=0 for 4 cycles, RETRY_CNT unchanged. Lock returns -> RUN again.
- Reset mid-SETTLE, with RELOCK asserted on the same edge as RESET -> all outputs at reset values; RETRY_CNT=0; normal sequence restarts.

Source files
------------

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL wrapper / system reset consumers.
// The master side is the sequencer; the slave side is whoever drives lock/relock and reads status.
interface pll_reset_sequencer_if #(
    parameter int MAX_RETRIES = 3
);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    logic               pll_lock;
    logic               relock;
    logic               pll_resetb;
    logic               sys_rst;
    logic               locked;
    logic               fault;
    logic [RETRY_W-1:0] retry_cnt;
    logic [2:0]         state;

    modport master (
        input  pll_lock,
        input  relock,
        output pll_resetb,
        output sys_rst,
        output locked,
        output fault,
        output retry_cnt,
        output state
    );

    modport slave (
        output pll_lock,
        output relock,
        input  pll_resetb,
        input  sys_rst,
        input  locked,
        input  fault,
        input  retry_cnt,
        input  state
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Power-up and lock-loss sequencer for the iCE40 PLL, running on the raw reference clock.
// Holds the PLL in reset, waits for a stable lock, then releases the downstream system reset.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 12000,
    parameter int STABLE_CYCLES = 256,
    parameter int LOSS_CYCLES   = 4,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    pll_reset_sequencer_if.master  bus
);

    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int LCNT_W    = (LOSS_CYCLES > 1) ? $clog2(LOSS_CYCLES) : 1;
    localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   WAIT_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [LCNT_W-1:0]  LOSS_LAST    = LCNT_W'(LOSS_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD   = 3'd0,
        S_WAIT   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t              cur_state;
    state_t              next_state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [LCNT_W-1:0]   lcnt;
    logic [LCNT_W-1:0]   lcnt_next;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [RETRY_W-1:0]  retry_next;
    logic                lock_meta;
    logic                lock_s;
    logic                do_retry;

    // Two-flop synchronizer for the asynchronous PLL lock, plus all sequencer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            cur_state <= S_HOLD;
            cnt       <= '0;
            lcnt      <= '0;
            retry_cnt <= '0;
        end else begin
            lock_meta <= bus.pll_lock;
            lock_s    <= lock_meta;
            cur_state <= next_state;
            cnt       <= cnt_next;
            lcnt      <= lcnt_next;
            retry_cnt <= retry_next;
        end
    end

    always_comb begin
        next_state = cur_state;
        cnt_next   = cnt + CNT_W'(1);
        lcnt_next  = lcnt;
        retry_next = retry_cnt;
        do_retry   = 1'b0;

        case (cur_state)
            S_HOLD: begin
                if (cnt == HOLD_LAST) next_state = S_WAIT;
            end
            S_WAIT: begin
                if (lock_s)                 next_state = S_SETTLE;
                else if (cnt == WAIT_LAST)  do_retry   = 1'b1;
            end
            S_SETTLE: begin
                if (!lock_s) begin
                    do_retry = 1'b1;
                end else if (cnt == SETTLE_LAST) begin
                    next_state = S_RUN;
                    retry_next = '0;
                end
            end
            S_RUN: begin
                cnt_next = cnt;
                if (lock_s)                  lcnt_next = '0;
                else if (lcnt == LOSS_LAST)  do_retry  = 1'b1;
                else                         lcnt_next = lcnt + LCNT_W'(1);
            end
            S_FAIL: begin
                cnt_next = cnt;
            end
            default: begin
                next_state = S_HOLD;
            end
        endcase

        // Failed attempts either loop back through HOLD or, once the budget is spent, latch FAIL.
        if (do_retry) begin
            if (retry_cnt == RETRY_LIMIT) begin
                next_state = S_FAIL;
            end else begin
                next_state = S_HOLD;
                retry_next = retry_cnt + RETRY_W'(1);
            end
        end

        if (bus.relock) begin
            next_state = S_HOLD;
            lcnt_next  = '0;
            retry_next = (cur_state == S_FAIL) ? '0 : retry_cnt;
        end

        if (next_state != cur_state || bus.relock) cnt_next = '0;
        if (next_state == S_RUN && cur_state != S_RUN) lcnt_next = '0;
    end

    assign bus.pll_resetb = (cur_state != S_HOLD) && (cur_state != S_FAIL);
    assign bus.sys_rst    = (cur_state != S_RUN);
    assign bus.locked     = (cur_state == S_RUN);
    assign bus.fault      = (cur_state == S_FAIL);
    assign bus.retry_cnt  = retry_cnt;
    assign bus.state      = cur_state;

endmodule
